// File: rtl/note_playback_scheduler.sv
// note_playback_scheduler: shares one tone output between the training prompt and
// keypress feedback. A fixed-priority arbiter (prompt over feedback) feeds a
// sequencer that latches the note, plays a square wave for NOTE_CYCLES clocks,
// stays silent for GAP_CYCLES clocks, then pulses done.
// Optional feature macro: NOTE_SCHED_PREEMPT_EN. When it is defined, a prompt
// request preempts a feedback note that is loading, playing or in its gap.
module note_playback_scheduler #(
    parameter int NOTE_CYCLES     = 25_000_000,
    parameter int GAP_CYCLES      = 2_500_000,
    parameter int DIV_SCALE_SHIFT = 0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       prompt_req,
    input  logic [2:0] prompt_note,
    output logic       prompt_ack,
    input  logic       fb_req,
    input  logic [2:0] fb_note,
    output logic       fb_ack,
    input  logic       abort,
    output logic       busy,
    output logic       tone_en,
    output logic       tone_out,
    output logic [2:0] cur_note,
    output logic       cur_src,
    output logic       done
);

    localparam logic [2:0] REST_NOTE = 3'd7;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] half_cnt;
    logic [31:0] dur_cnt;
    logic [31:0] gap_cnt;
    logic        tone_level;
    logic [15:0] cur_div;

    // Half-period divisor for a note; a shift that underflows to 0 is clamped to 1.
    function automatic logic [15:0] note_div(input logic [2:0] note);
        logic [15:0] base;
        logic [15:0] shifted;
        case (note)
            3'd0:    base = 16'd56818;
            3'd1:    base = 16'd50607;
            3'd2:    base = 16'd47778;
            3'd3:    base = 16'd42566;
            3'd4:    base = 16'd37921;
            3'd5:    base = 16'd35793;
            3'd6:    base = 16'd31888;
            default: base = 16'd1;
        endcase
        shifted = base >> DIV_SCALE_SHIFT;
        if (shifted == 16'd0) begin
            shifted = 16'd1;
        end
        return shifted;
    endfunction

    assign cur_div = note_div(cur_note);

    // State register; reset drops straight back to IDLE so nothing resumes.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: arbitration in IDLE, timed sequencing otherwise; abort overrides all.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (prompt_req || fb_req) begin
                    next_state = LOAD;
                end
            end
            LOAD: next_state = PLAY;
            PLAY: begin
                if (dur_cnt == 32'd0) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == 32'd0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
`ifdef NOTE_SCHED_PREEMPT_EN
        if ((state != IDLE) && cur_src && prompt_req) begin
            next_state = LOAD;
        end
`endif
        if (abort) begin
            next_state = IDLE;
        end
    end

    // Datapath: latch the winning request, run the duration, gap and half-period counters.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cur_note   <= 3'd0;
            cur_src    <= 1'b0;
            half_cnt   <= 16'd0;
            dur_cnt    <= 32'd0;
            gap_cnt    <= 32'd0;
            tone_level <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (next_state == LOAD) begin
                cur_src  <= ~prompt_req;
                cur_note <= prompt_req ? prompt_note : fb_note;
            end
            case (state)
                LOAD: begin
                    half_cnt   <= cur_div - 16'd1;
                    dur_cnt    <= 32'(NOTE_CYCLES - 1);
                    tone_level <= (cur_note != REST_NOTE);
                end
                PLAY: begin
                    if (dur_cnt != 32'd0) begin
                        dur_cnt <= dur_cnt - 32'd1;
                    end else begin
                        gap_cnt <= 32'(GAP_CYCLES - 1);
                    end
                    if (cur_note != REST_NOTE) begin
                        if (half_cnt == 16'd0) begin
                            tone_level <= ~tone_level;
                            half_cnt   <= cur_div - 16'd1;
                        end else begin
                            half_cnt <= half_cnt - 16'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt != 32'd0) begin
                        gap_cnt <= gap_cnt - 32'd1;
                    end
                end
                default: begin
                end
            endcase
            done <= (state == GAP) && (next_state == IDLE) && !abort;
        end
    end

    // Outputs decoded from state; the ack for the latched source is high only while in LOAD.
    always_comb begin
        busy       = (state != IDLE);
        tone_en    = (state == PLAY);
        tone_out   = (state == PLAY) && tone_level;
        prompt_ack = (state == LOAD) && !cur_src;
        fb_ack     = (state == LOAD) && cur_src;
    end

endmodule
